// File: rtl/stepper_move_sequencer.sv
// Single-axis stepper command sequencer: queued signed relative moves -> step/dir/enable pins.
// Define STEPPER_RAMP_EN to build the symmetric linear accel/decel period ramp.
module stepper_move_sequencer #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned STEP_HIGH  = 50,
  parameter int unsigned DIR_SETUP  = 25,
  parameter int unsigned RAMP_STEPS = 16,
  parameter int unsigned RAMP_INC   = 100
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [SIZE-1:0] cmd_steps_i,
  input  logic [SIZE-1:0] cmd_period_i,
  input  logic            abort_i,
  output logic            step_o,
  output logic            dir_o,
  output logic            enable_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [SIZE-1:0] position_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DIR_WAIT, S_STEP_HI, S_STEP_LO, S_DONE
  } state_t;

  localparam int unsigned     AW      = $clog2(CMD_DEPTH);
  localparam logic [SIZE-1:0] MIN_PER = SIZE'(2 * STEP_HIGH);
  localparam logic [SIZE-1:0] HI_CNT  = SIZE'(STEP_HIGH - 1);
  localparam logic [SIZE-1:0] LO_ADJ  = SIZE'(STEP_HIGH + 1);
  localparam logic [SIZE-1:0] DIR_CNT = SIZE'(DIR_SETUP - 1);

  state_t          state_q;
  logic [SIZE-1:0] cnt_q, rem_q, per_q, pos_q;
  logic            step_q, dir_q, done_q, en_q, abort_pend_q;

  logic [SIZE-1:0] steps_mem_q [CMD_DEPTH];
  logic [SIZE-1:0] per_mem_q   [CMD_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     fill_q;
  logic            full, empty, push, pop;

  logic [SIZE-1:0] head_steps, head_per, head_mag, eff_per, pos_d, cur_period;
  logic            head_dir;

  assign full        = fill_q == (AW+1)'(CMD_DEPTH);
  assign empty       = fill_q == '0;
  assign cmd_ready_o = !reset_i && !full && !abort_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == S_LOAD) && !abort_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      steps_mem_q[wr_q] <= cmd_steps_i;
      per_mem_q[wr_q]   <= cmd_period_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else if (abort_i) begin
      rd_q   <= wr_q;
      fill_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      fill_q <= fill_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head_steps = steps_mem_q[rd_q];
  assign head_per   = per_mem_q[rd_q];
  assign head_dir   = !head_steps[SIZE-1];
  // Negation of the most negative value yields 2^(SIZE-1), correct when read as unsigned.
  assign head_mag   = head_steps[SIZE-1] ? (~head_steps + SIZE'(1)) : head_steps;
  assign eff_per    = (head_per < MIN_PER) ? MIN_PER : head_per;
  assign pos_d      = dir_q ? pos_q + SIZE'(1) : pos_q - SIZE'(1);

`ifdef STEPPER_RAMP_EN
  localparam int unsigned RW = SIZE + 8;
  logic [SIZE-1:0] k_q, total_q, tail, near;
  logic [RW-1:0]   ramp_sum;

  always_comb begin
    tail       = total_q - SIZE'(1) - k_q;
    near       = (k_q < tail) ? k_q : tail;
    ramp_sum   = RW'(per_q);
    if (near < SIZE'(RAMP_STEPS))
      ramp_sum = ramp_sum + RW'(RAMP_INC) * RW'(SIZE'(RAMP_STEPS) - near);
    cur_period = (ramp_sum > RW'({SIZE{1'b1}})) ? '1 : ramp_sum[SIZE-1:0];
  end
`else
  assign cur_period = per_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      per_q        <= '0;
      pos_q        <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b1;
      done_q       <= 1'b0;
      en_q         <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef STEPPER_RAMP_EN
      k_q          <= '0;
      total_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      en_q   <= busy_o;
      case (state_q)
        S_IDLE: if (!empty && !abort_i) state_q <= S_LOAD;
        S_LOAD: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= head_mag;
            per_q <= eff_per;
`ifdef STEPPER_RAMP_EN
            k_q     <= '0;
            total_q <= head_mag;
`endif
            if (head_mag == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (head_dir != dir_q) begin
              dir_q   <= head_dir;
              cnt_q   <= DIR_CNT;
              state_q <= S_DIR_WAIT;
            end else begin
              state_q <= S_STEP_HI;
              step_q  <= 1'b1;
              cnt_q   <= HI_CNT;
              pos_q   <= pos_d;
            end
          end
        end
        S_DIR_WAIT: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= S_STEP_HI;
            step_q  <= 1'b1;
            cnt_q   <= HI_CNT;
            pos_q   <= pos_d;
          end else begin
            cnt_q <= cnt_q - SIZE'(1);
          end
        end
        // An abort seen during the pulse is remembered so the pulse still gets its full width.
        S_STEP_HI: begin
          if (abort_i) abort_pend_q <= 1'b1;
          if (cnt_q == '0) begin
            step_q <= 1'b0;
            if (abort_pend_q || abort_i) begin
              state_q      <= S_IDLE;
              abort_pend_q <= 1'b0;
            end else begin
              state_q <= S_STEP_LO;
              cnt_q   <= cur_period - LO_ADJ;
            end
          end else begin
            cnt_q <= cnt_q - SIZE'(1);
          end
        end
        S_STEP_LO: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            if (rem_q == SIZE'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              rem_q   <= rem_q - SIZE'(1);
`ifdef STEPPER_RAMP_EN
              k_q     <= k_q + SIZE'(1);
`endif
              state_q <= S_STEP_HI;
              step_q  <= 1'b1;
              cnt_q   <= HI_CNT;
              pos_q   <= pos_d;
            end
          end else begin
            cnt_q <= cnt_q - SIZE'(1);
          end
        end
        S_DONE: state_q <= (!empty && !abort_i) ? S_LOAD : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE) || !empty;
  assign enable_o   = busy_o || en_q;
  assign step_o     = step_q;
  assign dir_o      = dir_q;
  assign done_o     = done_q;
  assign position_o = pos_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed self-checking bench for stepper_move_sequencer (default parameters).
module tb_stepper_move_sequencer;

  logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [31:0] cmd_steps = '0, cmd_period = '0;
  logic        cmd_ready, step, dir, enable, busy, done;
  logic [31:0] position;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          rises[$], hiw[$], done_cyc[$];
  logic        rise_dir[$];
  logic [31:0] done_pos[$];
  int          done_cnt = 0, en_viol = 0, dir_viol = 0, last_rise = 0, dir_chg = 0;
  logic        step_prev = 1'b0, dir_prev = 1'b1;
  logic [31:0] exp_pos = '0;

  stepper_move_sequencer dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_steps_i(cmd_steps), .cmd_period_i(cmd_period), .abort_i(abort),
    .step_o(step), .dir_o(dir), .enable_o(enable), .busy_o(busy), .done_o(done),
    .position_o(position)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (step && !step_prev) begin
        rises.push_back(cyc);
        rise_dir.push_back(dir);
        last_rise = cyc;
      end
      if (!step && step_prev) hiw.push_back(cyc - last_rise);
      if (done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        done_pos.push_back(position);
      end
      if (dir !== dir_prev) begin
        dir_chg = cyc;
        if (step && step_prev) dir_viol++;
      end
      if (busy && !enable) en_viol++;
    end
    step_prev = step;
    dir_prev  = dir;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int exp_period(input int k, input int n, input int p);
    int m, r;
    m = (k < n - 1 - k) ? k : n - 1 - k;
    r = 0;
`ifdef STEPPER_RAMP_EN
    if (m < 16) r = 16 - m;
`endif
    return p + 100 * r;
  endfunction

  task automatic clear_mon();
    rises.delete(); hiw.delete(); done_cyc.delete(); rise_dir.delete(); done_pos.delete();
    done_cnt = 0;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] p,
                      output bit ok, output int acc, output int waited);
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = s; cmd_period = p;
    while (!cmd_ready && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    ok = cmd_ready;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 60000) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", cmd_ready); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({step, dir, enable, busy, done, cmd_ready} !== 6'b010001) begin
      errors++;
      $display("FAIL reset_outputs got step/dir/en/busy/done/rdy=%b want 010001",
               {step, dir, enable, busy, done, cmd_ready});
    end
    checks++;
    if (position !== 32'd0) begin errors++; $display("FAIL reset_position got %0d want 0", position); end
  endtask

  task automatic test_single_move();
    bit ok; int acc, w;
    clear_mon();
    push(32'd3, 32'd200, ok, acc, w);
    wait_idle(ok);
    exp_pos = exp_pos + 32'd3;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle timeout busy=%b want 0", busy); end
    checks++;
    if (enable !== 1'b1) begin errors++; $display("FAIL single_enable_hold got %b want 1", enable); end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0) begin errors++; $display("FAIL single_enable_off got %b want 0", enable); end
    checks++;
    if (rises.size() !== 3) begin errors++; $display("FAIL single_pulses got %0d want 3", rises.size()); end
    else begin
      checks++;
      if (rises[0] - acc !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", rises[0] - acc); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rises[i+1] - rises[i] !== exp_period(i, 3, 200)) begin
          errors++;
          $display("FAIL single_period[%0d] got %0d want %0d", i, rises[i+1] - rises[i], exp_period(i, 3, 200));
        end
      end
    end
    foreach (hiw[i]) begin
      checks++;
      if (hiw[i] !== 50) begin errors++; $display("FAIL single_high[%0d] got %0d want 50", i, hiw[i]); end
    end
    foreach (rise_dir[i]) begin
      checks++;
      if (rise_dir[i] !== 1'b1) begin errors++; $display("FAIL single_dir[%0d] got %b want 1", i, rise_dir[i]); end
    end
    checks++;
    if (position !== exp_pos) begin errors++; $display("FAIL single_position got %0d want %0d", position, exp_pos); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_dir_change();
    bit ok; int acc, w;
    logic exp_dir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    clear_mon();
    push(32'd2, 32'd200, ok, acc, w);
    push(-32'sd2, 32'd200, ok, acc, w);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dir_idle timeout busy=%b want 0", busy); end
    checks++;
    if (rises.size() !== 4) begin errors++; $display("FAIL dir_pulses got %0d want 4", rises.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rise_dir[i] !== exp_dir[i]) begin errors++; $display("FAIL dir_at_rise[%0d] got %b want %b", i, rise_dir[i], exp_dir[i]); end
      end
      checks++;
      if (rises[2] - dir_chg !== 25) begin errors++; $display("FAIL dir_setup got %0d want 25", rises[2] - dir_chg); end
      checks++;
      if (rises[2] - rises[1] !== exp_period(1, 2, 200) + 27) begin
        errors++; $display("FAIL dir_b2b_gap got %0d want %0d", rises[2] - rises[1], exp_period(1, 2, 200) + 27);
      end
    end
    checks++;
    if (done_cnt !== 2) begin errors++; $display("FAIL dir_done got %0d want 2", done_cnt); end
    else begin
      checks++;
      if (done_pos[0] !== exp_pos + 32'd2) begin errors++; $display("FAIL dir_pos_mid got %0d want %0d", done_pos[0], exp_pos + 32'd2); end
      checks++;
      if (done_pos[1] !== exp_pos) begin errors++; $display("FAIL dir_pos_end got %0d want %0d", done_pos[1], exp_pos); end
    end
    checks++;
    if (dir_viol !== 0) begin errors++; $display("FAIL dir_during_pulse got %0d want 0", dir_viol); end
  endtask

  task automatic test_fifo_full();
    bit ok, all_ok; int acc, w, w5;
    logic [31:0] cmds [5] = '{32'd1, 32'd2, -32'sd1, 32'd3, -32'sd2};
    logic [31:0] exp_done [6];
    exp_done[0] = exp_pos + 32'd2;
    for (int i = 0; i < 5; i++) exp_done[i+1] = exp_done[i] + cmds[i];
    clear_mon();
    all_ok = 1'b1;
    push(32'd2, 32'd100, ok, acc, w);
    all_ok &= ok;
    for (int i = 0; i < 5; i++) begin
      push(cmds[i], 32'd100, ok, acc, w);
      all_ok &= ok;
      if (i == 4) w5 = w;
    end
    checks++;
    if (!all_ok) begin errors++; $display("FAIL fifo_push timeout accepted=%b want 1", all_ok); end
    checks++;
    if (w5 === 0) begin errors++; $display("FAIL fifo_backpressure waited %0d cycles want >0", w5); end
    wait_idle(ok);
    exp_pos = exp_done[5];
    checks++;
    if (done_cnt !== 6) begin errors++; $display("FAIL fifo_done got %0d want 6", done_cnt); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (done_pos[i] !== exp_done[i]) begin errors++; $display("FAIL fifo_order[%0d] got %0d want %0d", i, done_pos[i], exp_done[i]); end
      end
    end
    checks++;
    if (rises.size() !== 11) begin errors++; $display("FAIL fifo_pulses got %0d want 11", rises.size()); end
  endtask

  task automatic test_abort();
    bit ok; int acc, w, n;
    clear_mon();
    push(32'd100, 32'd200, ok, acc, w);
    push(32'd5, 32'd200, ok, acc, w);
    n = 0;
    while (!step && n < 5000) begin @(negedge clk); n++; end
    repeat (9) @(negedge clk);
    abort = 1'b1; cmd_valid = 1'b1; cmd_steps = 32'd7; cmd_period = 32'd200;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", cmd_ready); end
    @(posedge clk);
    #1 abort = 1'b0; cmd_valid = 1'b0;
    n = 0;
    while (step && n < 200) begin @(negedge clk); n++; end
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy got %b want 0", busy); end
    checks++;
    if (hiw.size() !== 1 || hiw[0] !== 50) begin
      errors++; $display("FAIL abort_pulse_width got %0d pulses first %0d want 1 pulse of 50", hiw.size(), (hiw.size() > 0) ? hiw[0] : -1);
    end
    repeat (300) @(negedge clk);
    exp_pos = exp_pos + 32'd1;
    checks++;
    if (rises.size() !== 1) begin errors++; $display("FAIL abort_no_more_steps got %0d want 1", rises.size()); end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    checks++;
    if (position !== exp_pos) begin errors++; $display("FAIL abort_position got %0d want %0d", position, exp_pos); end
    checks++;
    if (enable !== 1'b0) begin errors++; $display("FAIL abort_enable got %b want 0", enable); end
  endtask

  task automatic test_zero_and_clamp();
    bit ok; int acc, w;
    clear_mon();
    push(32'd0, 32'd200, ok, acc, w);
    wait_idle(ok);
    checks++;
    if (done_cnt !== 1 || rises.size() !== 0) begin
      errors++; $display("FAIL zero_cmd got done=%0d steps=%0d want done=1 steps=0", done_cnt, rises.size());
    end else begin
      checks++;
      if (done_cyc[0] - acc > 3 || done_cyc[0] - acc < 1) begin
        errors++; $display("FAIL zero_latency got %0d want 1..3", done_cyc[0] - acc);
      end
    end
    clear_mon();
    push(32'd2, 32'd10, ok, acc, w);
    wait_idle(ok);
    exp_pos = exp_pos + 32'd2;
    checks++;
    if (rises.size() !== 2) begin errors++; $display("FAIL clamp_pulses got %0d want 2", rises.size()); end
    else begin
      checks++;
      if (rises[1] - rises[0] !== exp_period(0, 2, 100)) begin
        errors++; $display("FAIL clamp_period got %0d want %0d", rises[1] - rises[0], exp_period(0, 2, 100));
      end
    end
    checks++;
    if (position !== exp_pos) begin errors++; $display("FAIL clamp_position got %0d want %0d", position, exp_pos); end
    checks++;
    if (en_viol !== 0) begin errors++; $display("FAIL enable_vs_busy got %0d violations want 0", en_viol); end
  endtask

`ifdef STEPPER_RAMP_EN
  task automatic test_ramp();
    bit ok; int acc, w;
    clear_mon();
    push(32'd40, 32'd200, ok, acc, w);
    wait_idle(ok);
    exp_pos = exp_pos + 32'd40;
    checks++;
    if (rises.size() !== 40) begin errors++; $display("FAIL ramp_pulses got %0d want 40", rises.size()); end
    else begin
      for (int i = 0; i < 39; i++) begin
        checks++;
        if (rises[i+1] - rises[i] !== exp_period(i, 40, 200)) begin
          errors++; $display("FAIL ramp_period[%0d] got %0d want %0d", i, rises[i+1] - rises[i], exp_period(i, 40, 200));
        end
      end
    end
    checks++;
    if (position !== exp_pos) begin errors++; $display("FAIL ramp_position got %0d want %0d", position, exp_pos); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_move();
    test_dir_change();
    test_fifo_full();
    test_abort();
    test_zero_and_clamp();
`ifdef STEPPER_RAMP_EN
    test_ramp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
